// File: rtl/pzbcm_multi_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzbcm_multi_fifo_pkg: status-flag type and decode shared by multi FIFO   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pzbcm_multi_fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almost_full;
    logic full;
  } s_status_flag;

  function automatic s_status_flag get_status_flag(
    input int count,
    input int threshold,
    input int depth
  );
    s_status_flag flag;
    flag.empty       = (count == 0);
    flag.almost_full = (count >= threshold);
    flag.full        = (count >= depth);
    return flag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pzbcm_multi_fifo_channel_state.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzbcm_multi_fifo_channel_state: occupancy, local pointers and flags of   |
// | one logical FIFO partition. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
module pzbcm_multi_fifo_channel_state
  import pzbcm_multi_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int THRESHOLD     = DEPTH,
  parameter int FLAG_FF_OUT   = 1,
  localparam int COUNT_WIDTH   = $clog2(DEPTH + 1),
  localparam int POINTER_WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic                     i_pop,
  output logic [COUNT_WIDTH-1:0]   o_word_count,
  output logic [POINTER_WIDTH-1:0] o_write_pointer,
  output logic [POINTER_WIDTH-1:0] o_read_pointer,
  output s_status_flag             o_flag
);

  logic [COUNT_WIDTH-1:0]   r_word_count;
  logic [COUNT_WIDTH-1:0]   w_next_count;
  logic [POINTER_WIDTH-1:0] r_write_pointer;
  logic [POINTER_WIDTH-1:0] r_read_pointer;
  logic [POINTER_WIDTH-1:0] w_next_write_pointer;
  logic [POINTER_WIDTH-1:0] w_next_read_pointer;

  // Partitions need not be a power of two, so wrap explicitly at DEPTH-1.
  function automatic logic [POINTER_WIDTH-1:0] advance(input logic [POINTER_WIDTH-1:0] p);
    if (p == POINTER_WIDTH'(DEPTH - 1)) return '0;
    else                                return p + POINTER_WIDTH'(1);
  endfunction

  always_comb begin
    w_next_count         = r_word_count;
    w_next_write_pointer = r_write_pointer;
    w_next_read_pointer  = r_read_pointer;
    if (i_clear) begin
      w_next_count         = '0;
      w_next_write_pointer = '0;
      w_next_read_pointer  = '0;
    end else begin
      if (i_push) w_next_write_pointer = advance(r_write_pointer);
      if (i_pop)  w_next_read_pointer  = advance(r_read_pointer);
      case ({i_push, i_pop})
        2'b10:   w_next_count = r_word_count + COUNT_WIDTH'(1);
        2'b01:   w_next_count = r_word_count - COUNT_WIDTH'(1);
        default: w_next_count = r_word_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word_count    <= '0;
      r_write_pointer <= '0;
      r_read_pointer  <= '0;
    end else begin
      r_word_count    <= w_next_count;
      r_write_pointer <= w_next_write_pointer;
      r_read_pointer  <= w_next_read_pointer;
    end
  end

  generate
    if (FLAG_FF_OUT != 0) begin : g_flag_ff
      s_status_flag r_flag;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_flag <= get_status_flag(0, THRESHOLD, DEPTH);
        else          r_flag <= get_status_flag(int'(w_next_count), THRESHOLD, DEPTH);
      end
      assign o_flag = r_flag;
    end else begin : g_flag_comb
      assign o_flag = get_status_flag(int'(r_word_count), THRESHOLD, DEPTH);
    end
  endgenerate

  assign o_word_count    = r_word_count;
  assign o_write_pointer = r_write_pointer;
  assign o_read_pointer  = r_read_pointer;

endmodule
`default_nettype wire

// File: rtl/pzbcm_multi_fifo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pzbcm_multi_fifo_controller: CHANNELS logical FIFOs over one shared RAM  |
// | of CHANNELS*DEPTH words; request decode and address generation. Rev 1.0  |
// +--------------------------------------------------------------------------+
module pzbcm_multi_fifo_controller
  import pzbcm_multi_fifo_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int DEPTH             = 8,
  parameter int THRESHOLD         = DEPTH,
  parameter int FLAG_FF_OUT       = 1,
  parameter int CHANNEL_WIDTH     = (CHANNELS >= 2) ? $clog2(CHANNELS) : 1,
  parameter int RAM_POINTER_WIDTH = (CHANNELS * DEPTH >= 2) ? $clog2(CHANNELS * DEPTH) : 1,
  localparam int WORD_COUNT_WIDTH = $clog2(DEPTH + 1)
)(
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic                                       i_clear,
  input  logic [CHANNELS-1:0]                        i_clear_channel,
  input  logic                                       i_push,
  input  logic [CHANNEL_WIDTH-1:0]                   i_push_channel,
  input  logic                                       i_pop,
  input  logic [CHANNEL_WIDTH-1:0]                   i_pop_channel,
  output logic [CHANNELS-1:0]                        o_empty,
  output logic [CHANNELS-1:0]                        o_almost_full,
  output logic [CHANNELS-1:0]                        o_full,
  output logic [CHANNELS-1:0][WORD_COUNT_WIDTH-1:0]  o_word_count,
  output logic [RAM_POINTER_WIDTH-1:0]               o_write_pointer,
  output logic                                       o_write_to_ram,
  output logic [RAM_POINTER_WIDTH-1:0]               o_read_pointer,
  output logic                                       o_read_from_ram
);

  localparam int LOCAL_POINTER_WIDTH = (DEPTH >= 2) ? $clog2(DEPTH) : 1;

  logic [CHANNELS-1:0]          w_clear;
  logic [CHANNELS-1:0]          w_push;
  logic [CHANNELS-1:0]          w_pop;
  s_status_flag                 w_flag          [CHANNELS];
  logic [RAM_POINTER_WIDTH-1:0] w_write_address [CHANNELS];
  logic [RAM_POINTER_WIDTH-1:0] w_read_address  [CHANNELS];

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
      localparam logic [RAM_POINTER_WIDTH-1:0] c_base = RAM_POINTER_WIDTH'(i * DEPTH);
      logic [LOCAL_POINTER_WIDTH-1:0] w_local_write_pointer;
      logic [LOCAL_POINTER_WIDTH-1:0] w_local_read_pointer;

      // An out-of-range index matches no channel, so such requests vanish here.
      assign w_clear[i] = i_clear || i_clear_channel[i];
      assign w_push[i]  = i_push && (i_push_channel == CHANNEL_WIDTH'(i)) &&
                          !w_flag[i].full && !w_clear[i];
      assign w_pop[i]   = i_pop && (i_pop_channel == CHANNEL_WIDTH'(i)) &&
                          !w_flag[i].empty && !w_clear[i];

      pzbcm_multi_fifo_channel_state #(
        .DEPTH       (DEPTH),
        .THRESHOLD   (THRESHOLD),
        .FLAG_FF_OUT (FLAG_FF_OUT)
      ) u_channel_state (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_clear         (w_clear[i]),
        .i_push          (w_push[i]),
        .i_pop           (w_pop[i]),
        .o_word_count    (o_word_count[i]),
        .o_write_pointer (w_local_write_pointer),
        .o_read_pointer  (w_local_read_pointer),
        .o_flag          (w_flag[i])
      );

      assign w_write_address[i] = c_base + RAM_POINTER_WIDTH'(w_local_write_pointer);
      assign w_read_address[i]  = c_base + RAM_POINTER_WIDTH'(w_local_read_pointer);
      assign o_empty[i]         = w_flag[i].empty;
      assign o_almost_full[i]   = w_flag[i].almost_full;
      assign o_full[i]          = w_flag[i].full;
    end
  endgenerate

  always_comb begin
    o_write_pointer = '0;
    o_read_pointer  = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (i_push_channel == CHANNEL_WIDTH'(ch)) o_write_pointer = w_write_address[ch];
      if (i_pop_channel == CHANNEL_WIDTH'(ch))  o_read_pointer  = w_read_address[ch];
    end
  end

  assign o_write_to_ram  = |w_push;
  assign o_read_from_ram = |w_pop;

endmodule
`default_nettype wire

// File: tb/tb_pzbcm_multi_fifo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pzbcm_multi_fifo_controller: directed self-checking bench. Rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_pzbcm_multi_fifo_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance: CHANNELS=4, DEPTH=8, THRESHOLD=8, registered flags
  logic             a_clear;
  logic [3:0]       a_clear_channel;
  logic             a_push, a_pop;
  logic [1:0]       a_push_ch, a_pop_ch;
  logic [3:0]       a_empty, a_afull, a_full;
  logic [3:0][3:0]  a_wc;
  logic [4:0]       a_wp, a_rp;
  logic             a_wr, a_rd;

  pzbcm_multi_fifo_controller #(
    .CHANNELS(4), .DEPTH(8), .THRESHOLD(8), .FLAG_FF_OUT(1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(a_clear), .i_clear_channel(a_clear_channel),
    .i_push(a_push), .i_push_channel(a_push_ch), .i_pop(a_pop), .i_pop_channel(a_pop_ch),
    .o_empty(a_empty), .o_almost_full(a_afull), .o_full(a_full), .o_word_count(a_wc),
    .o_write_pointer(a_wp), .o_write_to_ram(a_wr), .o_read_pointer(a_rp),
    .o_read_from_ram(a_rd)
  );

  // Non-power-of-two channel count with THRESHOLD=6, both flag styles
  logic             b_push, b_pop;
  logic [1:0]       b_push_ch, b_pop_ch;
  logic [2:0]       b_empty, b_afull, b_full, c_empty, c_afull, c_full;
  logic [2:0][3:0]  b_wc, c_wc;
  logic [4:0]       b_wp, b_rp, c_wp, c_rp;
  logic             b_wr, b_rd, c_wr, c_rd;

  pzbcm_multi_fifo_controller #(
    .CHANNELS(3), .DEPTH(8), .THRESHOLD(6), .FLAG_FF_OUT(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_clear_channel(3'b000),
    .i_push(b_push), .i_push_channel(b_push_ch), .i_pop(b_pop), .i_pop_channel(b_pop_ch),
    .o_empty(b_empty), .o_almost_full(b_afull), .o_full(b_full), .o_word_count(b_wc),
    .o_write_pointer(b_wp), .o_write_to_ram(b_wr), .o_read_pointer(b_rp),
    .o_read_from_ram(b_rd)
  );

  pzbcm_multi_fifo_controller #(
    .CHANNELS(3), .DEPTH(8), .THRESHOLD(6), .FLAG_FF_OUT(0)
  ) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(1'b0), .i_clear_channel(3'b000),
    .i_push(b_push), .i_push_channel(b_push_ch), .i_pop(b_pop), .i_pop_channel(b_pop_ch),
    .o_empty(c_empty), .o_almost_full(c_afull), .o_full(c_full), .o_word_count(c_wc),
    .o_write_pointer(c_wp), .o_write_to_ram(c_wr), .o_read_pointer(c_rp),
    .o_read_from_ram(c_rd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_clear = 0; a_clear_channel = '0; a_push = 0; a_pop = 0;
    b_push = 0; b_pop = 0;
  endtask

  task automatic test_reset();
    idle();
    a_push_ch = 0; a_pop_ch = 0; b_push_ch = 0; b_pop_ch = 0;
    rst_n = 0;
    repeat (2) step();
    checks++;
    if (a_empty !== 4'hF || a_full !== 4'h0 || a_afull !== 4'h0) begin
      errors++; $display("FAIL reset_flags: empty=%b full=%b afull=%b expected 1111/0000/0000", a_empty, a_full, a_afull);
    end
    checks++;
    if (a_wc !== 16'h0 || a_wr !== 1'b0 || a_rd !== 1'b0) begin
      errors++; $display("FAIL reset_state: wc=%h wr=%b rd=%b expected 0000/0/0", a_wc, a_wr, a_rd);
    end
    checks++;
    if (b_empty !== 3'b111 || c_empty !== 3'b111) begin
      errors++; $display("FAIL reset_empty_bc: b=%b c=%b expected 111", b_empty, c_empty);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_push_ch2();
    for (int k = 0; k < 3; k++) begin
      a_push = 1; a_push_ch = 2;
      #1;
      checks++;
      if (a_wr !== 1'b1 || a_wp !== 5'(16 + k)) begin
        errors++; $display("FAIL push_ch2_%0d: wr=%b wp=%0d expected 1/%0d", k, a_wr, a_wp, 16 + k);
      end
      step();
    end
    a_push = 0;
    #1;
    checks++;
    if (a_wc[2] !== 4'd3 || a_empty !== 4'b1011) begin
      errors++; $display("FAIL push_ch2_state: wc2=%0d empty=%b expected 3/1011", a_wc[2], a_empty);
    end
  endtask

  task automatic test_full_ch1();
    for (int k = 0; k < 8; k++) begin
      a_push = 1; a_push_ch = 1;
      #1;
      checks++;
      if (a_wr !== 1'b1 || a_wp !== 5'(8 + k)) begin
        errors++; $display("FAIL fill_ch1_%0d: wr=%b wp=%0d expected 1/%0d", k, a_wr, a_wp, 8 + k);
      end
      step();
    end
    checks++;
    if (a_wc[1] !== 4'd8 || a_full[1] !== 1'b1 || a_afull[1] !== 1'b1) begin
      errors++; $display("FAIL full_ch1: wc1=%0d full1=%b afull1=%b expected 8/1/1", a_wc[1], a_full[1], a_afull[1]);
    end
    #1;
    checks++;
    if (a_wr !== 1'b0) begin
      errors++; $display("FAIL push_full_wr: wr=%b expected 0", a_wr);
    end
    step();
    checks++;
    if (a_wc[1] !== 4'd8) begin
      errors++; $display("FAIL push_full_count: wc1=%0d expected 8", a_wc[1]);
    end
    a_pop = 1; a_pop_ch = 1;
    #1;
    checks++;
    if (a_wr !== 1'b0 || a_rd !== 1'b1 || a_rp !== 5'd8) begin
      errors++; $display("FAIL full_pushpop: wr=%b rd=%b rp=%0d expected 0/1/8", a_wr, a_rd, a_rp);
    end
    step();
    idle();
    #1;
    checks++;
    if (a_wc[1] !== 4'd7 || a_full[1] !== 1'b0 || a_afull[1] !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_after: wc1=%0d full1=%b afull1=%b expected 7/0/0", a_wc[1], a_full[1], a_afull[1]);
    end
  endtask

  task automatic test_empty_pop_ch0();
    a_push = 1; a_push_ch = 0; a_pop = 1; a_pop_ch = 0;
    #1;
    checks++;
    if (a_rd !== 1'b0 || a_wr !== 1'b1 || a_wp !== 5'd0) begin
      errors++; $display("FAIL empty_pop: rd=%b wr=%b wp=%0d expected 0/1/0", a_rd, a_wr, a_wp);
    end
    step();
    idle();
    #1;
    checks++;
    if (a_wc[0] !== 4'd1 || a_empty[0] !== 1'b0) begin
      errors++; $display("FAIL empty_pop_after: wc0=%0d empty0=%b expected 1/0", a_wc[0], a_empty[0]);
    end
  endtask

  task automatic test_wrap_ch3();
    a_push = 1; a_push_ch = 3;
    step();
    for (int k = 0; k < 10; k++) begin
      a_push = 1; a_push_ch = 3; a_pop = 1; a_pop_ch = 3;
      #1;
      checks++;
      if (a_wr !== 1'b1 || a_rd !== 1'b1 || a_wp !== 5'(24 + (k + 1) % 8) || a_rp !== 5'(24 + k % 8)) begin
        errors++;
        $display("FAIL wrap_%0d: wr=%b rd=%b wp=%0d rp=%0d expected 1/1/%0d/%0d",
                 k, a_wr, a_rd, a_wp, a_rp, 24 + (k + 1) % 8, 24 + k % 8);
      end
      step();
    end
    idle();
    #1;
    checks++;
    if (a_wc[3] !== 4'd1 || a_wc[2] !== 4'd3) begin
      errors++; $display("FAIL wrap_counts: wc3=%0d wc2=%0d expected 1/3", a_wc[3], a_wc[2]);
    end
  endtask

  task automatic test_clear_channel();
    a_clear_channel = 4'b0010; a_push = 1; a_push_ch = 1; a_pop = 1; a_pop_ch = 2;
    #1;
    checks++;
    if (a_wr !== 1'b0 || a_rd !== 1'b1 || a_rp !== 5'd16) begin
      errors++; $display("FAIL clear_ch_req: wr=%b rd=%b rp=%0d expected 0/1/16", a_wr, a_rd, a_rp);
    end
    step();
    idle();
    a_push_ch = 1; a_pop_ch = 1;
    #1;
    checks++;
    if (a_wc[1] !== 4'd0 || a_empty[1] !== 1'b1 || a_wc[2] !== 4'd2) begin
      errors++; $display("FAIL clear_ch_counts: wc1=%0d empty1=%b wc2=%0d expected 0/1/2", a_wc[1], a_empty[1], a_wc[2]);
    end
    checks++;
    if (a_wp !== 5'd8 || a_rp !== 5'd8) begin
      errors++; $display("FAIL clear_ch_ptrs: wp=%0d rp=%0d expected 8/8", a_wp, a_rp);
    end
  endtask

  task automatic test_global_clear();
    a_clear = 1; a_push = 1; a_push_ch = 0;
    #1;
    checks++;
    if (a_wr !== 1'b0) begin
      errors++; $display("FAIL clear_push_wr: wr=%b expected 0", a_wr);
    end
    step();
    idle();
    #1;
    checks++;
    if (a_wc !== 16'h0 || a_empty !== 4'hF) begin
      errors++; $display("FAIL global_clear: wc=%h empty=%b expected 0000/1111", a_wc, a_empty);
    end
  endtask

  task automatic test_async_reset();
    a_push = 1; a_push_ch = 2;
    repeat (3) step();
    idle();
    rst_n = 0;
    #1;
    checks++;
    if (a_wc !== 16'h0 || a_empty !== 4'hF) begin
      errors++; $display("FAIL async_reset: wc=%h empty=%b expected 0000/1111", a_wc, a_empty);
    end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_out_of_range();
    b_push = 1; b_push_ch = 3; b_pop = 1; b_pop_ch = 3;
    #1;
    checks++;
    if (b_wr !== 1'b0 || b_rd !== 1'b0 || c_wr !== 1'b0 || c_rd !== 1'b0) begin
      errors++; $display("FAIL oor_req: b wr/rd=%b%b c wr/rd=%b%b expected 00/00", b_wr, b_rd, c_wr, c_rd);
    end
    step();
    idle();
    #1;
    checks++;
    if (b_wc !== 12'h0 || c_wc !== 12'h0 || b_empty !== 3'b111 || c_empty !== 3'b111) begin
      errors++; $display("FAIL oor_state: bwc=%h cwc=%h be=%b ce=%b expected 000/000/111/111", b_wc, c_wc, b_empty, c_empty);
    end
  endtask

  task automatic test_almost_full();
    for (int k = 0; k < 5; k++) begin
      b_push = 1; b_push_ch = 0;
      step();
    end
    checks++;
    if (b_wc[0] !== 4'd5 || b_afull !== 3'b000 || c_afull !== 3'b000) begin
      errors++; $display("FAIL afull_5: wc0=%0d b=%b c=%b expected 5/000/000", b_wc[0], b_afull, c_afull);
    end
    step();
    checks++;
    if (b_wc[0] !== 4'd6 || c_wc[0] !== 4'd6 || b_afull !== 3'b001 || c_afull !== 3'b001) begin
      errors++; $display("FAIL afull_6: bwc0=%0d cwc0=%0d b=%b c=%b expected 6/6/001/001", b_wc[0], c_wc[0], b_afull, c_afull);
    end
    checks++;
    if (b_full !== 3'b000 || c_full !== 3'b000) begin
      errors++; $display("FAIL afull_6_full: b=%b c=%b expected 000/000", b_full, c_full);
    end
    repeat (2) step();
    idle();
    #1;
    checks++;
    if (b_wc[0] !== 4'd8 || b_full !== 3'b001 || c_full !== 3'b001) begin
      errors++; $display("FAIL full_8: wc0=%0d b=%b c=%b expected 8/001/001", b_wc[0], b_full, c_full);
    end
  endtask

  initial begin
    test_reset();
    test_push_ch2();
    test_full_ch1();
    test_empty_pop_ch0();
    test_wrap_ch3();
    test_clear_channel();
    test_global_clear();
    test_async_reset();
    test_out_of_range();
    test_almost_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
